// File: rtl/pvt_mon_pkg.sv
// Shared types and constants for the PVT monitor pattern checker:
// checker FSM states and the 7-bit x^7+x^6+1 pattern generator constants.
package pvt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int             LFSR_W      = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
  localparam int             LFSR_TAP_HI = 6;
  localparam int             LFSR_TAP_LO = 5;

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1) producing the pattern bit that is
// launched into the hardened-flop chain. Reload wins over enable.
module lfsr7
  import pvt_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic pat_bit
);

  logic [LFSR_W-1:0] lfsr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, like real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
    end
  end

  assign pat_bit = lfsr[0];

endmodule

// File: rtl/seu_pattern_checker.sv
// Drives a PRBS7 pattern into a DICE flop chain and compares the returned bits
// against a delayed copy, counting mismatches over a programmable window.
module seu_pattern_checker #(
  parameter int CHAIN_LEN = 8,
  parameter int WIN_W     = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             pat_out,
  input  logic             chain_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat,
  output logic [WIN_W-1:0] first_err_idx
);

  import pvt_mon_pkg::*;

  localparam logic [WIN_W-1:0] PRIME_LAST = WIN_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WIN_W-1:0] NO_ERR_IDX = '1;

  state_t               state, state_nxt;
  logic [WIN_W-1:0]     win_q;
  logic [WIN_W-1:0]     phase_cnt;
  logic [CHAIN_LEN-1:0] dly;
  logic                 lfsr_bit;
  logic                 accept;
  logic                 mismatch;

  assign accept   = (state == IDLE) && start;
  assign busy     = (state == PRIME) || (state == CHECK);
  assign done     = (state == DONE);
  assign pat_out  = busy & lfsr_bit;
  assign mismatch = (state == CHECK) && (chain_q != dly[CHAIN_LEN-1]);

  lfsr7 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .enable  (busy),
    .pat_bit (lfsr_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = PRIME;
      PRIME: if (phase_cnt == PRIME_LAST) state_nxt = (win_q == '0) ? DONE : CHECK;
      CHECK: if (phase_cnt == win_q - WIN_W'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q         <= '0;
      phase_cnt     <= '0;
      dly           <= '0;
      err_count     <= '0;
      err_sat       <= 1'b0;
      first_err_idx <= NO_ERR_IDX;
    end else begin
      if (accept) begin
        win_q         <= window;
        phase_cnt     <= '0;
        err_count     <= '0;
        err_sat       <= 1'b0;
        first_err_idx <= NO_ERR_IDX;
      end

      if (busy) dly <= (dly << 1) | CHAIN_LEN'(pat_out);

      // The counter restarts at 0 on entry to CHECK so it doubles as the compare index.
      if (state == PRIME) begin
        phase_cnt <= (phase_cnt == PRIME_LAST) ? '0 : phase_cnt + WIN_W'(1);
      end else if (state == CHECK) begin
        phase_cnt <= phase_cnt + WIN_W'(1);
      end

      if (mismatch) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        if (err_count >= CNT_MAX - CNT_W'(1)) err_sat <= 1'b1;
        if (first_err_idx == NO_ERR_IDX) first_err_idx <= phase_cnt;
      end
    end
  end

endmodule

// File: tb/tb_seu_pattern_checker.sv
// Randomised bench for seu_pattern_checker: two instances (16-bit and 4-bit
// error counters) share stimulus; a PRBS7 reference and an error tally give expectations.
module tb_seu_pattern_checker;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] window;
  logic        cq_a, cq_b;
  logic        pat_a, pat_b, busy_a, busy_b, done_a, done_b, sat_a, sat_b;
  logic [15:0] cnt_a, first_a, first_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit ref_pat [0:511];
  bit flip    [0:255];

  always #5 clk = ~clk;

  seu_pattern_checker #(.CHAIN_LEN(L), .WIN_W(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .window(window), .pat_out(pat_a),
    .chain_q(cq_a), .busy(busy_a), .done(done_a), .err_count(cnt_a),
    .err_sat(sat_a), .first_err_idx(first_a)
  );

  seu_pattern_checker #(.CHAIN_LEN(L), .WIN_W(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .window(window), .pat_out(pat_b),
    .chain_q(cq_b), .busy(busy_b), .done(done_b), .err_count(cnt_b),
    .err_sat(sat_b), .first_err_idx(first_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_flips();
    for (int i = 0; i < 256; i++) flip[i] = 1'b0;
  endtask

  // One run: start, stream chain bits, observe outputs every cycle, then check results.
  // rst_at >= 0 asserts reset at that compare index instead of finishing the run.
  task automatic run(input string tag, input int win, input bit invert_all,
                     input bit stray_start, input int rst_at);
    int errs = 0, first = -1, last = L + win + 3;
    int done_cyc_a = -1, done_cyc_b = -1, n_done_a = 0, n_done_b = 0;
    int pat_bad = 0, busy_bad = 0;
    logic [15:0] cnt_a_d = '0, first_a_d = '0, first_b_d = '0;
    logic [3:0]  cnt_b_d = '0;
    @(negedge clk);
    start  = 1'b1;
    window = win[15:0];
    @(negedge clk);
    start  = 1'b0;
    window = 16'($urandom);
    check({tag, " first_pat"}, {31'd0, pat_a}, 32'd1);
    for (int c = 1; c <= last; c++) begin
      int  idx    = c - L - 1;
      bit  e_busy = (c <= L + win);
      bit  e_pat  = e_busy ? ref_pat[c-1] : 1'b0;
      if (rst_at >= 0 && idx == rst_at) begin
        check({tag, " pre_rst_cnt"}, cnt_a, errs);
        rst = 1'b1;
        #1;
        check({tag, " rst_cnt_a"},   cnt_a, 0);
        check({tag, " rst_cnt_b"},   cnt_b, 0);
        check({tag, " rst_busy"},    busy_a, 0);
        check({tag, " rst_pat"},     pat_a, 0);
        check({tag, " rst_first"},   first_a, 32'hFFFF);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (done_a || done_b) n_done_a++;
        end
        check({tag, " rst_no_done"}, n_done_a, 0);
        rst = 1'b0;
        return;
      end
      if (pat_a !== e_pat || pat_b !== e_pat) pat_bad++;
      if (busy_a !== e_busy || busy_b !== e_busy) busy_bad++;
      if (done_a === 1'b1) begin
        n_done_a++;
        if (done_cyc_a < 0) done_cyc_a = c;
        cnt_a_d = cnt_a; cnt_b_d = cnt_b; first_a_d = first_a; first_b_d = first_b;
      end
      if (done_b === 1'b1) begin
        n_done_b++;
        if (done_cyc_b < 0) done_cyc_b = c;
      end
      if (idx >= 0 && idx < win) begin
        bit f = invert_all | flip[idx];
        cq_a = ref_pat[idx] ^ f;
        cq_b = ref_pat[idx] ^ f;
        if (f) begin
          errs++;
          if (first < 0) first = idx;
        end
      end else begin
        cq_a = 1'($urandom);
        cq_b = 1'($urandom);
      end
      start  = stray_start && ((c == L + 3 && win > 3) || c == L + win + 1);
      window = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " pattern"},   pat_bad, 0);
    check({tag, " busy"},      busy_bad, 0);
    check({tag, " done_cyc_a"}, done_cyc_a, L + win + 1);
    check({tag, " done_cyc_b"}, done_cyc_b, L + win + 1);
    check({tag, " n_done"},    n_done_a + n_done_b, 2);
    check({tag, " cnt_a"},     cnt_a, min_int(errs, 65535));
    check({tag, " cnt_b"},     cnt_b, min_int(errs, 15));
    check({tag, " cnt_a_done"}, cnt_a_d, min_int(errs, 65535));
    check({tag, " cnt_b_done"}, cnt_b_d, min_int(errs, 15));
    check({tag, " sat_a"},     sat_a, 0);
    check({tag, " sat_b"},     sat_b, (errs >= 15) ? 1 : 0);
    check({tag, " first_a"},   first_a, (first < 0) ? 32'hFFFF : first);
    check({tag, " first_b"},   first_b, (first < 0) ? 32'hFFFF : first);
    check({tag, " first_done"}, first_a_d, (first < 0) ? 32'hFFFF : first);
    check({tag, " first_b_done"}, first_b_d, (first < 0) ? 32'hFFFF : first);
  endtask

  initial begin
    int s = 1;
    for (int i = 0; i < 512; i++) begin
      ref_pat[i] = s[0];
      s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 127;
    end

    rst = 1'b1; start = 1'b0; window = '0; cq_a = 1'b0; cq_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cnt",   cnt_a, 0);
    check("reset first", first_a, 32'hFFFF);
    check("reset busy",  {busy_a, done_a, pat_a, sat_a}, 0);
    rst = 1'b0;
    @(negedge clk);

    clear_flips();
    run("loopback", 100, 1'b0, 1'b0, -1);

    flip[5] = 1'b1; flip[40] = 1'b1;
    run("inject", 100, 1'b0, 1'b0, -1);

    clear_flips();
    run("saturate", 50, 1'b1, 1'b0, -1);
    run("zero_win", 0, 1'b0, 1'b0, -1);

    flip[12] = 1'b1;
    run("ignored_start", 30, 1'b0, 1'b1, -1);

    clear_flips();
    flip[1] = 1'b1; flip[2] = 1'b1; flip[3] = 1'b1;
    run("mid_reset", 30, 1'b0, 1'b0, 6);
    clear_flips();
    run("after_reset", 20, 1'b0, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      int win = $urandom_range(1, 120);
      int nf  = $urandom_range(0, 20);
      clear_flips();
      for (int j = 0; j < nf; j++) flip[$urandom_range(0, win - 1)] = 1'b1;
      run($sformatf("rand%0d", r), win, ($urandom_range(0, 3) == 0), 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
